cfa_blend_mix: RTL and testbench
================================

Name: cfa_blend_mix

Overview:
- Consumes the 8-bit blend weight w_grad_f produced by the gradient-weight stage (equ_15).
- Mixes two candidate interpolated CFA samples: pix_out = round(w*pix_a + (255-w)*pix_b) / 255.
- Sits directly downstream of the weight stage and feeds the output sample writer.
- Three-stage pipeline with valid/ready handshake on both sides so downstream back-pressure never drops or duplicates samples.

Parameters:
- DW, 8: pixel width of pix_a, pix_b and pix_out. The weight is always 8 bits and full scale is 255.
- CNT_W, 16: width of the accepted-sample counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- w_grad_f  input  8  blend weight; 255 selects pix_a fully, 0 selects pix_b fully.
- pix_a  input  DW  interpolation candidate A.
- pix_b  input  DW  interpolation candidate B.
- in_last  input  1  end-of-line tag; carried alongside the sample.
- in_valid  input  1  input sample present.
- in_ready  output  1  block can accept a sample this cycle.
- pix_out  output  DW  blended sample.
- out_last  output  1  in_last delayed with its sample.
- out_valid  output  1  pix_out/out_last valid.
- out_ready  input  1  downstream accepts this cycle.
- sample_cnt  output  CNT_W  number of output handshakes since reset; wraps.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits 0, out_valid=0, pix_out=0, out_last=0, sample_cnt=0. Data registers are cleared too, so no stale value is ever observable.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational). The whole pipeline moves together when adv=1 and holds completely when adv=0.
- Input acceptance: a sample is accepted when in_valid && in_ready. Bubbles propagate as valid=0 stages.
- S1 registers:
  - p_a = w*pix_a (DW+8 bits)
  - p_b = (255-w)*pix_b (DW+8 bits)
  - valid, last
- S2 registers:
  - sum = p_a + p_b (DW+9 bits; no overflow because sum <= 255*(2^DW-1))
  - valid, last
- S3 (output) registers:
  - pix_out = floor((2*sum + 255) / 510), i.e. round-half-up of sum/255. Result is always <= 2^DW-1, so no saturation is needed.
  - Any shift/add realisation is acceptable only if it is bit-exact over the full sum range.
  - out_valid, out_last
- Latency: 3 cycles from acceptance to out_valid, with no stalls. Throughput is 1 sample/cycle.
- Hold on stall: while out_valid && !out_ready, pix_out, out_last and out_valid are held stable. At most 3 samples are in flight; in_ready=0.
- Output with ready high: out_valid=1 && out_ready=1 in the same cycle as a new S2 valid loads the next sample with no bubble.
- Counter: sample_cnt increments on every out_valid && out_ready and wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: in-flight samples are discarded. After rst returns high, the first out_valid is no earlier than 3 cycles after the first new acceptance.
- in_valid=0 with in_ready=1: a bubble enters and no count changes.
- Boundary weights:
  - w=255 gives exactly pix_a.
  - w=0 gives exactly pix_b.
  - pix_a=pix_b gives that value for any w.

Decomposition:
- Shared package holds:
  - WMAX=255 and the weight width (8)
  - a function/localparam for the sum width (DW+9)
  - the rounding constant 255 and divisor 510
- One natural sub-module: div255_round. It is combinational, sum in and rounded quotient out, and is used in S3. It can be exhaustively tested standalone for DW=8 (sum 0..65025).

Test Plan:
- Reset: hold rst=0 for 5 cycles with in_valid=1 and random data -> out_valid=0, pix_out=0, sample_cnt=0, in_ready=1 throughout.
- Endpoints:
  - w=255, a=200, b=10 -> pix_out=200 exactly 3 cycles after acceptance.
  - w=0, a=200, b=10 -> 10.
  - w=77, a=b=123 -> 123.
- Rounding:
  - w=128, a=255, b=0 -> 128
  - w=1, a=128, b=0 -> 1 (128/255 rounds up)
  - w=64, a=100, b=50 -> 63 (15950/255=62.55)
  - w=1, a=127, b=0 -> 0
- Back-pressure: stream 10 consecutive samples with out_ready low for cycles 4-8.
  - in_ready drops after 3 in flight and the held pix_out is stable.
  - On release, all 10 emerge in order with no loss or duplication; sample_cnt=10.
  - out_last matches its sample.
- Async reset mid-stream: pull rst low between clock edges with 2 samples in flight.
  - out_valid falls immediately, before the next edge.
  - After release, only newly accepted samples appear.
- Random soak: 10k random w/a/b with random in_valid and out_ready -> every output matches the reference model floor((2*sum+255)/510). sample_cnt equals the handshake count modulo 2^16, including one forced wrap.

Source files
------------

// File: rtl/cfa_blend_mix_pkg.sv
// Shared constants for the CFA blend/mix stage.
// Weight is 8 bits with full scale 255; sums carry DW+9 bits.
package cfa_blend_mix_pkg;

  localparam int WW   = 8;
  localparam int WMAX = 255;
  localparam int RND  = 255;
  localparam int DIV  = 510;

  function automatic int sum_w(input int dw);
    return dw + 9;
  endfunction

endpackage

// File: rtl/cfa_blend_mix_if.sv
// Sample stream bundle for the blend/mix stage.
// Input side and output side each use a valid/ready pair.
interface cfa_blend_mix_if
  import cfa_blend_mix_pkg::*;
#(
  parameter int DW = 8
);

  logic [WW-1:0] w_grad_f;
  logic [DW-1:0] pix_a;
  logic [DW-1:0] pix_b;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pix_out;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output w_grad_f, pix_a, pix_b,
    output in_last, in_valid, out_ready,
    input  in_ready, pix_out,
    input  out_last, out_valid
  );

  modport slave (
    input  w_grad_f, pix_a, pix_b,
    input  in_last, in_valid, out_ready,
    output in_ready, pix_out,
    output out_last, out_valid
  );

endinterface

// File: rtl/cfa_blend_mix_div255_round.sv
// Rounded divide by 255: q = floor((2*sum+255)/510).
// Uses floor((sum+127)/255) with a shift/fold reduction.
module cfa_blend_mix_div255_round
  import cfa_blend_mix_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = sum_w(DW)
) (
  input  logic [SW-1:0] sum,
  output logic [DW-1:0] q
);

  localparam int NIT = (SW + 7) / 8;

  logic [SW-1:0] z;
  logic [DW-1:0] acc;

  // Each fold keeps acc + floor(z/255) invariant: 256k+l = 255k + (k+l)
  always_comb begin
    z   = sum + SW'(RND / 2);
    acc = '0;
    for (int i = 0; i < NIT; i++) begin
      acc = acc + DW'(z >> 8);
      z   = (z >> 8) + {{(SW-8){1'b0}}, z[7:0]};
    end
    if (z >= SW'(WMAX))
      acc = acc + DW'(1);
    q = acc;
  end

endmodule

// File: rtl/cfa_blend_mix.sv
// Three-stage weighted blend of two CFA candidates.
// Whole pipeline advances together when the output slot frees.
module cfa_blend_mix
  import cfa_blend_mix_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  cfa_blend_mix_if.slave   bus,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int PW = DW + WW;
  localparam int SW = sum_w(DW);

  logic          adv;
  logic [WW-1:0] wc;

  logic          v1, l1;
  logic [PW-1:0] pa, pb;

  logic          v2, l2;
  logic [SW-1:0] sum;

  logic          ov, ol;
  logic [DW-1:0] po;
  logic [DW-1:0] q;

  assign adv          = !ov || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = ov;
  assign bus.out_last  = ol;
  assign bus.pix_out   = po;
  assign wc = WW'(WMAX) - bus.w_grad_f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      pa <= '0;
      pb <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        pa <= PW'(bus.w_grad_f) * PW'(bus.pix_a);
        pb <= PW'(wc) * PW'(bus.pix_b);
        l1 <= bus.in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2  <= 1'b0;
      l2  <= 1'b0;
      sum <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        sum <= SW'(pa) + SW'(pb);
        l2  <= l1;
      end
    end
  end

  cfa_blend_mix_div255_round #(
    .DW (DW),
    .SW (SW)
  ) u_div (
    .sum (sum),
    .q   (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov <= 1'b0;
      ol <= 1'b0;
      po <= '0;
    end else if (adv) begin
      ov <= v2;
      if (v2) begin
        po <= q;
        ol <= l2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sample_cnt <= '0;
    else if (ov && bus.out_ready)
      sample_cnt <= sample_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_cfa_blend_mix.sv
// Bench for cfa_blend_mix: vector table, stall/reset
// sequences and a random soak against a queue model.
module tb_cfa_blend_mix;
  import cfa_blend_mix_pkg::*;

  typedef struct {
    int pix;
    bit last;
  } exp_t;

  typedef struct {
    int w;
    int a;
    int b;
    bit last;
    int exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sample_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_m = 0;
  exp_t q[$];

  cfa_blend_mix_if #(.DW(8)) bus();

  cfa_blend_mix #(
    .DW    (8),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  function automatic int ref_pix(int w, int a, int b);
    int s;
    s = w * a + (WMAX - w) * b;
    return (2 * s + RND) / DIV;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, int w, int a, int b,
                       bit l, bit rdy);
    bus.in_valid  = v;
    bus.w_grad_f  = 8'(w);
    bus.pix_a     = 8'(a);
    bus.pix_b     = 8'(b);
    bus.in_last   = l;
    bus.out_ready = rdy;
  endtask

  task automatic drive_rnd(bit v, bit rdy);
    drive(v, int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), rdy);
  endtask

  // One clock: check, model the edge, return at next negedge.
  task automatic cyc(output bit acc);
    bit   ohs;
    exp_t e;
    #1;
    chk("cnt", sample_cnt, cnt_m % 65536);
    chk("in_ready", bus.in_ready,
        !bus.out_valid || bus.out_ready);
    acc = bus.in_valid && bus.in_ready;
    ohs = bus.out_valid && bus.out_ready;
    if (ohs) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0d expected none",
                 bus.pix_out);
      end else begin
        e = q.pop_front();
        chk("pix", bus.pix_out, e.pix);
        chk("last", bus.out_last, e.last);
      end
    end
    if (acc) begin
      e.pix  = ref_pix(int'(bus.w_grad_f), int'(bus.pix_a),
                       int'(bus.pix_b));
      e.last = bus.in_last;
      q.push_back(e);
    end
    @(posedge clk);
    if (ohs) cnt_m++;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[10];
    bit   acc;
    int   c, sent, base, held, n_in, ncyc;
    int   bw[10], ba[10], bb[10];

    tbl[0] = '{255, 200,  10, 1'b0, 200};
    tbl[1] = '{  0, 200,  10, 1'b1,  10};
    tbl[2] = '{ 77, 123, 123, 1'b0, 123};
    tbl[3] = '{128, 255,   0, 1'b1, 128};
    tbl[4] = '{  1, 128,   0, 1'b0,   1};
    tbl[5] = '{ 64, 100,  50, 1'b1,  63};
    tbl[6] = '{  1, 127,   0, 1'b0,   0};
    tbl[7] = '{255, 255,   0, 1'b1, 255};
    tbl[8] = '{  0,   0, 255, 1'b0, 255};
    tbl[9] = '{200,   0,   0, 1'b1,   0};

    drive(0, 0, 0, 0, 0, 1);
    // Reset held low with live input traffic
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_rnd(1, 1'($urandom_range(0, 1)));
      #1;
      chk("rst_ovalid", bus.out_valid, 0);
      chk("rst_pix", bus.pix_out, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_iready", bus.in_ready, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    rst = 1'b1;

    // Vector table: single samples with exact latency
    foreach (tbl[i]) begin
      drive(1, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].last, 1);
      cyc(acc);
      chk("tbl_acc", acc, 1);
      drive(0, 0, 0, 0, 0, 1);
      cyc(acc);
      #1;
      chk("tbl_lat2", bus.out_valid, 0);
      cyc(acc);
      #1;
      chk("tbl_lat3", bus.out_valid, 1);
      chk("tbl_pix", bus.pix_out, tbl[i].exp);
      chk("tbl_last", bus.out_last, tbl[i].last);
      cyc(acc);
    end

    // Back-pressure: 10 samples, out_ready low cycles 4-8
    for (int i = 0; i < 10; i++) begin
      bw[i] = int'($urandom_range(0, 255));
      ba[i] = int'($urandom_range(0, 255));
      bb[i] = int'($urandom_range(0, 255));
    end
    base = cnt_m;
    sent = 0;
    held = 0;
    c    = 1;
    while ((sent < 10 || q.size() != 0) && c < 60) begin
      if (sent < 10)
        drive(1, bw[sent], ba[sent], bb[sent],
              1'(sent % 3 == 2), !(c >= 4 && c <= 8));
      else
        drive(0, 0, 0, 0, 0, 1);
      #1;
      if (c >= 4 && c <= 8) begin
        chk("bp_iready", bus.in_ready, 0);
        chk("bp_ovalid", bus.out_valid, 1);
        if (c == 4) held = int'(bus.pix_out);
        else chk("bp_hold", bus.pix_out, held);
      end
      cyc(acc);
      if (acc) sent++;
      c++;
    end
    chk("bp_timeout", c < 60, 1);
    #1;
    chk("bp_cnt", sample_cnt, (base + 10) % 65536);

    // Async reset with samples in flight and output stalled
    for (int i = 0; i < 3; i++) begin
      drive_rnd(1, 1);
      cyc(acc);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_pre_ovalid", bus.out_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_ovalid", bus.out_valid, 0);
    chk("ar_iready", bus.in_ready, 1);
    chk("ar_cnt", sample_cnt, 0);
    chk("ar_pix", bus.pix_out, 0);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rnd(1, 1);
      cyc(acc);
    end
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(acc);
    chk("ar_drain", q.size(), 0);
    chk("ar_cnt3", cnt_m, 3);

    // Random soak then full-rate run through the counter wrap
    n_in = 0;
    ncyc = 0;
    while (cnt_m < 65540 && ncyc < 85000) begin
      if (n_in < 10000)
        drive_rnd(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0));
      else
        drive_rnd(1, 1);
      cyc(acc);
      if (acc) n_in++;
      ncyc++;
    end
    chk("soak_timeout", cnt_m >= 65540, 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(acc);
    chk("soak_drain", q.size(), 0);
    #1;
    chk("soak_cnt", sample_cnt, cnt_m % 65536);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
